// File: rtl/down_count_checker.sv
// down_count_checker
// ------------------
// Sequence monitor for a 2-bit synchronous down counter (3->2->1->0->3).
// Locks after LOCK_N consecutive correct transitions. While locked it flags
// mismatches (seq_err), counts them (err_count) and counts correct 0->3
// wrap-arounds (wrap_pulse / wrap_count). ERR_LIMIT consecutive mismatches
// drop it back to acquisition.
//
// Optional feature: define DCC_HOLD_OK_EN to make a repeated sample
// (q_in == previous sample) neutral in ACQUIRE and LOCKED instead of a mismatch.
//
// Ports:
//   clk        rising-edge clock, shared with the counter
//   reset      asynchronous active-high reset, clears all state
//   q_in       counter output Q[1:0]
//   q_valid    sample q_in this cycle
//   locked     high while in LOCKED
//   seq_err    one-cycle pulse on a mismatch while LOCKED
//   wrap_pulse one-cycle pulse on a correct 0->3 transition while LOCKED
//   expected   next expected value, (last sample - 1) mod 4
//   wrap_count saturating count of LOCKED wrap-arounds
//   err_count  saturating count of seq_err events

module down_count_checker #(
    parameter int CNT_W     = 8,
    parameter int LOCK_N    = 4,
    parameter int ERR_LIMIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       q_in,
    input  logic             q_valid,
    output logic             locked,
    output logic             seq_err,
    output logic             wrap_pulse,
    output logic [1:0]       expected,
    output logic [CNT_W-1:0] wrap_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACQUIRE = 2'b01,
        ST_LOCKED  = 2'b10
    } state_t;

    localparam logic [3:0] LOCK_N_C    = 4'(LOCK_N);
    localparam logic [3:0] ERR_LIMIT_C = 4'(ERR_LIMIT);

    state_t           state_q, state_d;
    logic [1:0]       prev_q, prev_d;
    logic [1:0]       expected_q, expected_d;
    logic [3:0]       good_cnt_q, good_cnt_d;
    logic [3:0]       bad_cnt_q, bad_cnt_d;
    logic             locked_q, locked_d;
    logic             seq_err_q, seq_err_d;
    logic             wrap_pulse_q, wrap_pulse_d;
    logic [CNT_W-1:0] wrap_count_q, wrap_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic is_match;
    logic hold_ok;

    assign is_match = (q_in == (prev_q - 2'd1));

`ifdef DCC_HOLD_OK_EN
    // A repeated value is treated as "counter paused": no progress, no error.
    assign hold_ok = (q_in == prev_q);
`else
    assign hold_ok = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        expected_d   = expected_q;
        good_cnt_d   = good_cnt_q;
        bad_cnt_d    = bad_cnt_q;
        locked_d     = locked_q;
        seq_err_d    = 1'b0;
        wrap_pulse_d = 1'b0;
        wrap_count_d = wrap_count_q;
        err_count_d  = err_count_q;

        // prev tracks the actual count in every state so the checker resyncs.
        if (q_valid) begin
            prev_d     = q_in;
            expected_d = q_in - 2'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (q_valid) begin
                    state_d    = ST_ACQUIRE;
                    good_cnt_d = 4'd0;
                end
            end

            ST_ACQUIRE: begin
                if (q_valid && !hold_ok) begin
                    if (is_match) begin
                        good_cnt_d = good_cnt_q + 4'd1;
                        if ((good_cnt_q + 4'd1) == LOCK_N_C) begin
                            state_d   = ST_LOCKED;
                            locked_d  = 1'b1;
                            bad_cnt_d = 4'd0;
                        end
                    end else begin
                        good_cnt_d = 4'd0;
                    end
                end
            end

            ST_LOCKED: begin
                if (q_valid && !hold_ok) begin
                    if (is_match) begin
                        bad_cnt_d = 4'd0;
                        if (prev_q == 2'd0 && q_in == 2'd3) begin
                            wrap_pulse_d = 1'b1;
                            if (wrap_count_q != {CNT_W{1'b1}}) begin
                                wrap_count_d = wrap_count_q + 1'b1;
                            end
                        end
                    end else begin
                        // seq_err fires even on the mismatch that drops lock.
                        seq_err_d = 1'b1;
                        if (err_count_q != {CNT_W{1'b1}}) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if ((bad_cnt_q + 4'd1) == ERR_LIMIT_C) begin
                            state_d    = ST_ACQUIRE;
                            good_cnt_d = 4'd0;
                            bad_cnt_d  = 4'd0;
                            locked_d   = 1'b0;
                        end else begin
                            bad_cnt_d = bad_cnt_q + 4'd1;
                        end
                    end
                end
            end

            default: begin
                // Unused encoding recovers to IDLE on the next clock.
                state_d  = ST_IDLE;
                locked_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            prev_q       <= 2'd0;
            expected_q   <= 2'b11;
            good_cnt_q   <= 4'd0;
            bad_cnt_q    <= 4'd0;
            locked_q     <= 1'b0;
            seq_err_q    <= 1'b0;
            wrap_pulse_q <= 1'b0;
            wrap_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            expected_q   <= expected_d;
            good_cnt_q   <= good_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            locked_q     <= locked_d;
            seq_err_q    <= seq_err_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_count_q <= wrap_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign locked     = locked_q;
    assign seq_err    = seq_err_q;
    assign wrap_pulse = wrap_pulse_q;
    assign expected   = expected_q;
    assign wrap_count = wrap_count_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_down_count_checker.sv
// tb_down_count_checker
// ---------------------
// Directed bench for down_count_checker. A default-width instance and a
// CNT_W=2 instance see identical stimulus; the second one shows wrap_count
// and err_count saturating at 3.

module tb_down_count_checker;

   logic       clk;
   logic       reset;
   logic [1:0] q_in;
   logic       q_valid;

   logic       locked, seq_err, wrap_pulse;
   logic [1:0] expected;
   logic [7:0] wrap_count, err_count;

   logic       s_locked, s_seq_err, s_wrap_pulse;
   logic [1:0] s_expected;
   logic [1:0] s_wrap_count, s_err_count;

   int checks;
   int failures;
   int hold_err;

   // Main instance with default parameters.
   down_count_checker #(.CNT_W(8), .LOCK_N(4), .ERR_LIMIT(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .q_in       (q_in),
      .q_valid    (q_valid),
      .locked     (locked),
      .seq_err    (seq_err),
      .wrap_pulse (wrap_pulse),
      .expected   (expected),
      .wrap_count (wrap_count),
      .err_count  (err_count)
   );

   // Narrow-counter instance used to watch saturation.
   down_count_checker #(.CNT_W(2), .LOCK_N(4), .ERR_LIMIT(2)) dut_sat (
      .clk        (clk),
      .reset      (reset),
      .q_in       (q_in),
      .q_valid    (q_valid),
      .locked     (s_locked),
      .seq_err    (s_seq_err),
      .wrap_pulse (s_wrap_pulse),
      .expected   (s_expected),
      .wrap_count (s_wrap_count),
      .err_count  (s_err_count)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it, and on mismatch counts and reports the failure.
   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Drive one sample after the falling edge, then let the rising edge take it
   // and settle so the registered result is visible.
   task automatic applyStimulus(input logic [1:0] q, input logic v);
      @(negedge clk);
      q_in    = q;
      q_valid = v;
      @(posedge clk);
      #1;
   endtask

   // Valid sample plus checks of every main-instance output.
   task automatic stepCheck(input string tag, input logic [1:0] q, input logic exp_lock,
                            input logic exp_err, input logic exp_wrap,
                            input logic [7:0] exp_wc, input logic [7:0] exp_ec);
      logic [1:0] exp_nx;
      exp_nx = q - 2'd1;
      applyStimulus(q, 1'b1);
      checkOutput({tag, ".locked"},     {7'd0, locked},     {7'd0, exp_lock});
      checkOutput({tag, ".seq_err"},    {7'd0, seq_err},    {7'd0, exp_err});
      checkOutput({tag, ".wrap_pulse"}, {7'd0, wrap_pulse}, {7'd0, exp_wrap});
      checkOutput({tag, ".expected"},   {6'd0, expected},   {6'd0, exp_nx});
      checkOutput({tag, ".wrap_count"}, wrap_count,         exp_wc);
      checkOutput({tag, ".err_count"},  err_count,          exp_ec);
   endtask

   // Linear directed sequence with hand-computed expectations.
   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      q_in     = 2'd0;
      q_valid  = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst.locked",     {7'd0, locked},     8'd0);
      checkOutput("rst.seq_err",    {7'd0, seq_err},    8'd0);
      checkOutput("rst.wrap_pulse", {7'd0, wrap_pulse}, 8'd0);
      checkOutput("rst.expected",   {6'd0, expected},   8'd3);
      checkOutput("rst.wrap_count", wrap_count,         8'd0);
      checkOutput("rst.err_count",  err_count,          8'd0);

      @(negedge clk);
      reset = 1'b0;

      // Acquire: seed 3, then four correct transitions (0->3 wrap not counted).
      stepCheck("acq0", 2'd3, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      stepCheck("acq1", 2'd2, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      stepCheck("acq2", 2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      stepCheck("acq3", 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      stepCheck("acq4", 2'd3, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);

      // Locked run with two wraps.
      stepCheck("run0", 2'd2, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      stepCheck("run1", 2'd1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      stepCheck("run2", 2'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      stepCheck("run3", 2'd3, 1'b1, 1'b0, 1'b1, 8'd1, 8'd0);
      stepCheck("run4", 2'd2, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0);
      stepCheck("run5", 2'd1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0);
      stepCheck("run6", 2'd0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0);
      stepCheck("run7", 2'd3, 1'b1, 1'b0, 1'b1, 8'd2, 8'd0);

      // Invalid cycle: pulse drops, nothing else moves.
      applyStimulus(2'd0, 1'b0);
      checkOutput("gap.wrap_pulse", {7'd0, wrap_pulse}, 8'd0);
      checkOutput("gap.expected",   {6'd0, expected},   8'd2);
      checkOutput("gap.wrap_count", wrap_count,         8'd2);
      checkOutput("gap.locked",     {7'd0, locked},     8'd1);

      // Single mismatch at prev=1 keeps lock.
      stepCheck("se0", 2'd2, 1'b1, 1'b0, 1'b0, 8'd2, 8'd0);
      stepCheck("se1", 2'd1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd0);
      stepCheck("se2", 2'd3, 1'b1, 1'b1, 1'b0, 8'd2, 8'd1);
      stepCheck("se3", 2'd2, 1'b1, 1'b0, 1'b0, 8'd2, 8'd1);
      stepCheck("se4", 2'd1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd1);

      // Two consecutive mismatches at prev=2 drop lock on the second.
      stepCheck("dl0", 2'd0, 1'b1, 1'b0, 1'b0, 8'd2, 8'd1);
      stepCheck("dl1", 2'd3, 1'b1, 1'b0, 1'b1, 8'd3, 8'd1);
      stepCheck("dl2", 2'd2, 1'b1, 1'b0, 1'b0, 8'd3, 8'd1);
      stepCheck("dl3", 2'd0, 1'b1, 1'b1, 1'b0, 8'd3, 8'd2);
      stepCheck("dl4", 2'd2, 1'b0, 1'b1, 1'b0, 8'd3, 8'd3);

      // Relock needs four correct transitions; the ACQUIRE wrap is not counted.
      stepCheck("rl0", 2'd1, 1'b0, 1'b0, 1'b0, 8'd3, 8'd3);
      stepCheck("rl1", 2'd0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd3);
      stepCheck("rl2", 2'd3, 1'b0, 1'b0, 1'b0, 8'd3, 8'd3);
      stepCheck("rl3", 2'd2, 1'b1, 1'b0, 1'b0, 8'd3, 8'd3);
      checkOutput("rl3.sat_wrap", {6'd0, s_wrap_count}, 8'd3);

      // More wraps: main counts on, CNT_W=2 instance holds at 3 but still pulses.
      stepCheck("sw0", 2'd1, 1'b1, 1'b0, 1'b0, 8'd3, 8'd3);
      stepCheck("sw1", 2'd0, 1'b1, 1'b0, 1'b0, 8'd3, 8'd3);
      stepCheck("sw2", 2'd3, 1'b1, 1'b0, 1'b1, 8'd4, 8'd3);
      checkOutput("sw2.sat_pulse", {7'd0, s_wrap_pulse}, 8'd1);
      checkOutput("sw2.sat_wrap",  {6'd0, s_wrap_count}, 8'd3);
      stepCheck("sw3", 2'd2, 1'b1, 1'b0, 1'b0, 8'd4, 8'd3);
      stepCheck("sw4", 2'd1, 1'b1, 1'b0, 1'b0, 8'd4, 8'd3);
      stepCheck("sw5", 2'd0, 1'b1, 1'b0, 1'b0, 8'd4, 8'd3);
      stepCheck("sw6", 2'd3, 1'b1, 1'b0, 1'b1, 8'd5, 8'd3);
      checkOutput("sw6.sat_wrap",  {6'd0, s_wrap_count}, 8'd3);

      // Repeated value: neutral with the hold option, mismatch otherwise.
      stepCheck("hd0", 2'd2, 1'b1, 1'b0, 1'b0, 8'd5, 8'd3);
      stepCheck("hd1", 2'd1, 1'b1, 1'b0, 1'b0, 8'd5, 8'd3);
`ifdef DCC_HOLD_OK_EN
      hold_err = 0;
`else
      hold_err = 1;
`endif
      stepCheck("hd2", 2'd1, 1'b1, hold_err[0], 1'b0, 8'd5, 8'd3 + 8'(hold_err));
      stepCheck("hd3", 2'd0, 1'b1, 1'b0, 1'b0, 8'd5, 8'd3 + 8'(hold_err));
      checkOutput("hd3.sat_err", {6'd0, s_err_count}, 8'd3);

      // Asynchronous reset mid-cycle, away from any clock edge.
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("arst.locked",     {7'd0, locked},     8'd0);
      checkOutput("arst.seq_err",    {7'd0, seq_err},    8'd0);
      checkOutput("arst.wrap_pulse", {7'd0, wrap_pulse}, 8'd0);
      checkOutput("arst.expected",   {6'd0, expected},   8'd3);
      checkOutput("arst.wrap_count", wrap_count,         8'd0);
      checkOutput("arst.err_count",  err_count,          8'd0);
      checkOutput("arst.sat_wrap",   {6'd0, s_wrap_count}, 8'd0);

      @(negedge clk);
      reset = 1'b0;

      // Invalid cycles after reset change nothing; the next valid sample seeds.
      applyStimulus(2'd1, 1'b0);
      checkOutput("idle.expected", {6'd0, expected}, 8'd3);
      checkOutput("idle.locked",   {7'd0, locked},   8'd0);
      stepCheck("post0", 2'd3, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
